// File: rtl/axi_aw_w_rr_arbiter.sv
// Round-robin AW/W arbiter sharing one slave write port among up to four masters.
// The grant index is prefixed onto the slave AWID; B responses are steered back by that prefix.
module axi_aw_w_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ATTR_WIDTH  = 17
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  output logic [NUM_MASTERS-1:0]            m_awready,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_awid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [NUM_MASTERS*4-1:0]          m_awlen,
  input  logic [NUM_MASTERS*3-1:0]          m_awsize,
  input  logic [NUM_MASTERS*2-1:0]          m_awburst,
  input  logic [NUM_MASTERS*ATTR_WIDTH-1:0] m_awattr,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_wready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]            m_wlast,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  output logic [ID_WIDTH-1:0]               m_bid,
  output logic [1:0]                        m_bresp,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [ID_WIDTH+1:0]               s_awid,
  output logic [ADDR_WIDTH-1:0]             s_awaddr,
  output logic [3:0]                        s_awlen,
  output logic [2:0]                        s_awsize,
  output logic [1:0]                        s_awburst,
  output logic [ATTR_WIDTH-1:0]             s_awattr,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [DATA_WIDTH/8-1:0]           s_wstrb,
  output logic                              s_wlast,
  input  logic                              s_bvalid,
  input  logic [ID_WIDTH+1:0]               s_bid,
  input  logic [1:0]                        s_bresp,
  output logic                              s_bready,
  output logic [1:0]                        grant_idx,
  output logic                              busy
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

  state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [1:0] pick_s;
  logic [1:0] cand_s;
  logic       found_s;
  logic [NUM_MASTERS-1:0] grant_oh_s;
  logic       sel_wvalid_s;
  logic [ID_WIDTH-1:0] sel_awid_s;
  logic [1:0] bk_s;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Rotating priority search starting one past the last winner.
  always_comb begin
    found_s = 1'b0;
    pick_s  = last_q;
    cand_s  = 2'd0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand_s = 2'((int'(last_q) + i) % NUM_MASTERS);
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found_s && (cand_s == 2'(j)) && m_awvalid[j]) begin
          found_s = 1'b1;
          pick_s  = cand_s;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  always_comb begin
    grant_oh_s   = '0;
    sel_awid_s   = '0;
    s_awaddr     = '0;
    s_awlen      = 4'd0;
    s_awsize     = 3'd0;
    s_awburst    = 2'd0;
    s_awattr     = '0;
    sel_wvalid_s = 1'b0;
    s_wdata      = '0;
    s_wstrb      = '0;
    s_wlast      = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == 2'(i)) begin
        grant_oh_s[i] = 1'b1;
        sel_awid_s    = m_awid[i*ID_WIDTH +: ID_WIDTH];
        s_awaddr      = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_awlen       = m_awlen[i*4 +: 4];
        s_awsize      = m_awsize[i*3 +: 3];
        s_awburst     = m_awburst[i*2 +: 2];
        s_awattr      = m_awattr[i*ATTR_WIDTH +: ATTR_WIDTH];
        sel_wvalid_s  = m_wvalid[i];
        s_wdata       = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_wstrb       = m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
        s_wlast       = m_wlast[i];
      end else begin
        grant_oh_s[i] = 1'b0;
      end
    end
  end

  assign s_awid    = {grant_q, sel_awid_s};
  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          grant_d = pick_s;
          last_d  = pick_s;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        s_awvalid = 1'b1;
        m_awready = grant_oh_s & {NUM_MASTERS{s_awready}};
        if (s_awready) begin
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        s_wvalid = sel_wvalid_s;
        m_wready = grant_oh_s & {NUM_MASTERS{s_wready}};
        if (sel_wvalid_s && s_wready && s_wlast) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Responses whose prefix names no existing master are accepted and dropped.
  always_comb begin
    bk_s     = s_bid[ID_WIDTH+1:ID_WIDTH];
    m_bvalid = '0;
    s_bready = 1'b1;
    m_bid    = s_bid[ID_WIDTH-1:0];
    m_bresp  = s_bresp;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (bk_s == 2'(i)) begin
        m_bvalid[i] = s_bvalid;
        s_bready    = m_bready[i];
      end else begin
        m_bvalid[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_aw_w_rr_arbiter.sv
// Directed self-checking bench for axi_aw_w_rr_arbiter (4-master instance plus a
// 3-master instance used only to exercise the out-of-range B prefix).
module tb_axi_aw_w_rr_arbiter;
  logic         clk, rst_n;
  logic [3:0]   m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [15:0]  m_awid, m_awlen, m_wstrb;
  logic [127:0] m_awaddr, m_wdata;
  logic [11:0]  m_awsize;
  logic [7:0]   m_awburst;
  logic [67:0]  m_awattr;
  logic [3:0]   m_bid;
  logic [1:0]   m_bresp;
  logic         s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [5:0]   s_awid, s_bid;
  logic [31:0]  s_awaddr, s_wdata;
  logic [3:0]   s_awlen, s_wstrb;
  logic [2:0]   s_awsize;
  logic [1:0]   s_awburst, s_bresp, grant_idx;
  logic [16:0]  s_awattr;
  logic         busy;

  logic [2:0]   m3_awready, m3_wready, m3_bvalid, m3_bready;
  logic [3:0]   m3_bid, s3_awlen, s3_wstrb;
  logic [1:0]   m3_bresp, s3_awburst, g3_idx;
  logic         s3_awvalid, s3_wvalid, s3_wlast, s3_bready, busy3;
  logic [5:0]   s3_awid;
  logic [31:0]  s3_awaddr, s3_wdata;
  logic [2:0]   s3_awsize;
  logic [16:0]  s3_awattr;

  int vec_cnt = 0;
  int err_cnt = 0;

  axi_aw_w_rr_arbiter u_dut (
    .ACLK(clk), .ARESETn(rst_n),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awattr(m_awattr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awattr(s_awattr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp), .s_bready(s_bready),
    .grant_idx(grant_idx), .busy(busy)
  );

  axi_aw_w_rr_arbiter #(.NUM_MASTERS(3)) u_dut3 (
    .ACLK(clk), .ARESETn(rst_n),
    .m_awvalid(3'b000), .m_awready(m3_awready), .m_awid(12'h000), .m_awaddr(96'h0),
    .m_awlen(12'h000), .m_awsize(9'h000), .m_awburst(6'h00), .m_awattr(51'h0),
    .m_wvalid(3'b000), .m_wready(m3_wready), .m_wdata(96'h0), .m_wstrb(12'h000), .m_wlast(3'b000),
    .m_bvalid(m3_bvalid), .m_bready(m3_bready), .m_bid(m3_bid), .m_bresp(m3_bresp),
    .s_awvalid(s3_awvalid), .s_awready(1'b0), .s_awid(s3_awid), .s_awaddr(s3_awaddr),
    .s_awlen(s3_awlen), .s_awsize(s3_awsize), .s_awburst(s3_awburst), .s_awattr(s3_awattr),
    .s_wvalid(s3_wvalid), .s_wready(1'b0), .s_wdata(s3_wdata), .s_wstrb(s3_wstrb), .s_wlast(s3_wlast),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp), .s_bready(s3_bready),
    .grant_idx(g3_idx), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m_awvalid = 4'h0; m_wvalid = 4'h0; m_wlast = 4'h0; m_bready = 4'h0; m3_bready = 3'b000;
    m_awlen = 16'h0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b0; s_bid = 6'h00; s_bresp = 2'b00;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    m_awvalid = 4'hF; m_wvalid = 4'hF; s_awready = 1'b1; s_wready = 1'b1;
    #3;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
    vec_cnt++; if (s_awvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_awvalid: got %b want 0", s_awvalid); end
    vec_cnt++; if (s_wvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_wvalid: got %b want 0", s_wvalid); end
    vec_cnt++; if (m_awready !== 4'h0) begin err_cnt++; $display("FAIL rst_awready: got %b want 0000", m_awready); end
    vec_cnt++; if (m_wready !== 4'h0) begin err_cnt++; $display("FAIL rst_wready: got %b want 0000", m_wready); end
    vec_cnt++; if (grant_idx !== 2'd0) begin err_cnt++; $display("FAIL rst_grant: got %0d want 0", grant_idx); end
    tick(); tick();
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_first_grant;
    m_awvalid = 4'b0101;
    #1;
    vec_cnt++; if (s_awvalid !== 1'b0) begin err_cnt++; $display("FAIL fg_nolatency: got %b want 0", s_awvalid); end
    tick();
    vec_cnt++; if (s_awvalid !== 1'b1) begin err_cnt++; $display("FAIL fg_awvalid: got %b want 1", s_awvalid); end
    vec_cnt++; if (grant_idx !== 2'd0) begin err_cnt++; $display("FAIL fg_grant: got %0d want 0", grant_idx); end
    vec_cnt++; if (s_awid !== 6'h05) begin err_cnt++; $display("FAIL fg_awid: got %h want 05", s_awid); end
    vec_cnt++; if (s_awaddr !== 32'h1000_0000) begin err_cnt++; $display("FAIL fg_awaddr: got %h want 10000000", s_awaddr); end
    s_awready = 1'b1;
    #1;
    vec_cnt++; if (m_awready !== 4'b0001) begin err_cnt++; $display("FAIL fg_awready: got %b want 0001", m_awready); end
    tick();
    m_awvalid = 4'b0100; m_wvalid = 4'b0001; m_wlast = 4'b0101; s_wready = 1'b1;
    #1;
    vec_cnt++; if (s_wvalid !== 1'b1) begin err_cnt++; $display("FAIL fg_wvalid: got %b want 1", s_wvalid); end
    vec_cnt++; if (s_wdata !== 32'hD000_0000) begin err_cnt++; $display("FAIL fg_wdata: got %h want d0000000", s_wdata); end
    vec_cnt++; if (m_wready !== 4'b0001) begin err_cnt++; $display("FAIL fg_wready: got %b want 0001", m_wready); end
    tick();
    m_wvalid = 4'b0000;
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL fg_bubble: got busy %b want 0", busy); end
    tick();
    vec_cnt++; if (grant_idx !== 2'd2) begin err_cnt++; $display("FAIL fg_grant2: got %0d want 2", grant_idx); end
    vec_cnt++; if (s_awid !== 6'h27) begin err_cnt++; $display("FAIL fg_awid2: got %h want 27", s_awid); end
    tick();
    m_awvalid = 4'b0000; m_wvalid = 4'b0100;
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g;
    do_reset();
    m_awvalid = 4'hF; m_wvalid = 4'hF; m_wlast = 4'hF; s_awready = 1'b1; s_wready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 2'(k % 4);
      vec_cnt++; if (s_awvalid !== 1'b1 || grant_idx !== exp_g) begin err_cnt++; $display("FAIL rr_grant[%0d]: got awvalid %b grant %0d want 1 grant %0d", k, s_awvalid, grant_idx, exp_g); end
      vec_cnt++; if (s_awid[5:4] !== exp_g) begin err_cnt++; $display("FAIL rr_prefix[%0d]: got %0d want %0d", k, s_awid[5:4], exp_g); end
      tick();
      vec_cnt++; if (s_awvalid !== 1'b0 || s_wvalid !== 1'b1 || m_awready !== 4'h0) begin err_cnt++; $display("FAIL rr_data[%0d]: got awvalid %b wvalid %b awready %b want 0 1 0000", k, s_awvalid, s_wvalid, m_awready); end
      vec_cnt++; if (s_wdata !== (32'hD000_0000 + 32'(k % 4))) begin err_cnt++; $display("FAIL rr_wdata[%0d]: got %h want %h", k, s_wdata, 32'hD000_0000 + 32'(k % 4)); end
      tick();
      vec_cnt++; if (busy !== 1'b0 || s_awvalid !== 1'b0) begin err_cnt++; $display("FAIL rr_idle[%0d]: got busy %b awvalid %b want 0 0", k, busy, s_awvalid); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_multibeat;
    int beat, hs;
    logic [3:0] exp_wr;
    do_reset();
    m_awvalid = 4'b0010; m_awlen[7:4] = 4'd3; m_wvalid = 4'b0001; s_awready = 1'b1;
    tick();
    vec_cnt++; if (grant_idx !== 2'd1 || s_awlen !== 4'd3) begin err_cnt++; $display("FAIL mb_aw: got grant %0d len %0d want 1 3", grant_idx, s_awlen); end
    tick();
    m_awvalid = 4'b0000;
    beat = 0; hs = 0;
    for (int cyc = 0; cyc < 12 && beat < 4; cyc++) begin
      m_wvalid = 4'b0011;
      m_wdata[63:32] = 32'hB000_0000 + 32'(beat);
      m_wlast[1] = (beat == 3);
      s_wready = (cyc % 2 == 0);
      #1;
      exp_wr = {2'b00, s_wready, 1'b0};
      vec_cnt++; if (m_wready !== exp_wr) begin err_cnt++; $display("FAIL mb_wready[%0d]: got %b want %b", cyc, m_wready, exp_wr); end
      vec_cnt++; if (s_wdata !== 32'hB000_0000 + 32'(beat)) begin err_cnt++; $display("FAIL mb_wdata[%0d]: got %h want %h", cyc, s_wdata, 32'hB000_0000 + 32'(beat)); end
      if (s_wvalid && s_wready) hs++;
      tick();
      if (s_wready) beat++;
    end
    m_wvalid = 4'b0000;
    #1;
    vec_cnt++; if (hs !== 4) begin err_cnt++; $display("FAIL mb_handshakes: got %0d want 4", hs); end
    vec_cnt++; if (busy !== 1'b0 || m_wready !== 4'h0) begin err_cnt++; $display("FAIL mb_end: got busy %b wready %b want 0 0000", busy, m_wready); end
    clear_inputs();
  endtask

  task automatic test_w_before_aw;
    do_reset();
    m_awvalid = 4'b1001; m_wvalid = 4'b1000; m_wlast = 4'b1001; s_awready = 1'b1; s_wready = 1'b1;
    m_wdata[127:96] = 32'h3333_3333; m_wdata[31:0] = 32'h0000_0C0C;
    #1;
    vec_cnt++; if (m_wready !== 4'h0) begin err_cnt++; $display("FAIL wa_idle: got %b want 0000", m_wready); end
    tick();
    vec_cnt++; if (grant_idx !== 2'd0 || m_wready !== 4'h0) begin err_cnt++; $display("FAIL wa_addr: got grant %0d wready %b want 0 0000", grant_idx, m_wready); end
    tick();
    m_awvalid = 4'b1000;
    #1;
    vec_cnt++; if (s_wvalid !== 1'b0 || m_wready[3] !== 1'b0) begin err_cnt++; $display("FAIL wa_stall: got wvalid %b wready3 %b want 0 0", s_wvalid, m_wready[3]); end
    m_wvalid = 4'b1001;
    #1;
    vec_cnt++; if (s_wdata !== 32'h0000_0C0C || m_wready !== 4'b0001) begin err_cnt++; $display("FAIL wa_m0: got data %h wready %b want 00000c0c 0001", s_wdata, m_wready); end
    tick();
    m_wvalid = 4'b1000;
    tick();
    vec_cnt++; if (grant_idx !== 2'd3 || m_wready !== 4'h0) begin err_cnt++; $display("FAIL wa_g3: got grant %0d wready %b want 3 0000", grant_idx, m_wready); end
    tick();
    m_awvalid = 4'b0000;
    #1;
    vec_cnt++; if (m_wready !== 4'b1000 || s_wdata !== 32'h3333_3333) begin err_cnt++; $display("FAIL wa_m3: got wready %b data %h want 1000 33333333", m_wready, s_wdata); end
    tick();
    m_wvalid = 4'b0000;
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL wa_done: got busy %b want 0", busy); end
    clear_inputs();
  endtask

  task automatic test_b_path;
    s_bvalid = 1'b1; s_bid = 6'b10_1010; s_bresp = 2'b10; m_bready = 4'b0100; m3_bready = 3'b100;
    #1;
    vec_cnt++; if (m_bvalid !== 4'b0100) begin err_cnt++; $display("FAIL b_valid: got %b want 0100", m_bvalid); end
    vec_cnt++; if (m_bid !== 4'hA || m_bresp !== 2'b10) begin err_cnt++; $display("FAIL b_payload: got id %h resp %b want a 10", m_bid, m_bresp); end
    vec_cnt++; if (s_bready !== 1'b1) begin err_cnt++; $display("FAIL b_ready1: got %b want 1", s_bready); end
    vec_cnt++; if (m3_bvalid !== 3'b100) begin err_cnt++; $display("FAIL b3_valid2: got %b want 100", m3_bvalid); end
    m_bready = 4'b1011;
    #1;
    vec_cnt++; if (s_bready !== 1'b0) begin err_cnt++; $display("FAIL b_ready0: got %b want 0", s_bready); end
    s_bid = 6'b11_0101; m_bready = 4'b0111; m3_bready = 3'b000;
    #1;
    vec_cnt++; if (m_bvalid !== 4'b1000 || s_bready !== 1'b0) begin err_cnt++; $display("FAIL b_m3: got valid %b ready %b want 1000 0", m_bvalid, s_bready); end
    vec_cnt++; if (m3_bvalid !== 3'b000 || s3_bready !== 1'b1) begin err_cnt++; $display("FAIL b3_sink: got valid %b ready %b want 000 1", m3_bvalid, s3_bready); end
    s_bvalid = 1'b0;
    #1;
    vec_cnt++; if (m_bvalid !== 4'h0) begin err_cnt++; $display("FAIL b_idle: got %b want 0000", m_bvalid); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    m_awvalid = 4'b0010; m_awlen[7:4] = 4'd3; s_awready = 1'b1;
    tick();
    tick();
    m_awvalid = 4'b0000; m_wvalid = 4'b0010; m_wlast = 4'b0000; s_wready = 1'b1;
    tick();
    vec_cnt++; if (s_wvalid !== 1'b1 || busy !== 1'b1) begin err_cnt++; $display("FAIL rm_beat2: got wvalid %b busy %b want 1 1", s_wvalid, busy); end
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (s_wvalid !== 1'b0 || busy !== 1'b0 || m_wready !== 4'h0) begin err_cnt++; $display("FAIL rm_drop: got wvalid %b busy %b wready %b want 0 0 0000", s_wvalid, busy, m_wready); end
    vec_cnt++; if (grant_idx !== 2'd0) begin err_cnt++; $display("FAIL rm_grant: got %0d want 0", grant_idx); end
    m_wvalid = 4'b0000; m_awvalid = 4'b0011;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vec_cnt++; if (s_awvalid !== 1'b1 || s_awid !== 6'h05) begin err_cnt++; $display("FAIL rm_regrant: got awvalid %b awid %h want 1 05", s_awvalid, s_awid); end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    m_awid = {4'h9, 4'h7, 4'h6, 4'h5};
    m_awsize = 12'h0; m_awburst = 8'h55; m_awattr = 68'h0; m_wstrb = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      m_awaddr[i*32 +: 32] = 32'h1000_0000 * 32'(i + 1);
      m_wdata[i*32 +: 32]  = 32'hD000_0000 + 32'(i);
    end
    test_reset();
    test_first_grant();
    test_round_robin();
    for (int i = 0; i < 4; i++) m_wdata[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    test_multibeat();
    test_w_before_aw();
    test_b_path();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
